// File: rtl/instr_pkg.sv
// Field positions, legal-opcode encodings and the per-entry decoded record
// shared by the instruction decode queue and its field extractor.
package instr_pkg;

  localparam int INSTR_W = 16;
  localparam int IMM_W   = 16;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;
  localparam int RD_HI   = 10;
  localparam int RD_LO   = 8;
  localparam int RM_HI   = 7;
  localparam int RM_LO   = 5;
  localparam int RN_HI   = 4;
  localparam int RN_LO   = 2;
  localparam int ALU_HI  = 1;
  localparam int ALU_LO  = 0;
  localparam int COND_HI = 11;
  localparam int COND_LO = 8;
  localparam int IMM5_HI = 4;
  localparam int IMM8_HI = 7;
  localparam int LBL8_HI = 7;
  localparam int LBL11_HI = 10;

  // Legal opcode encodings: whole 00xxx group, 10000, 1100x and 11100.
  localparam logic [1:0] OPC_GRP_00   = 2'b00;
  localparam logic [4:0] OPC_10000    = 5'b10000;
  localparam logic [3:0] OPC_GRP_1100 = 4'b1100;
  localparam logic [4:0] OPC_11100    = 5'b11100;

  // Immediates are held at instruction width; widening to DATA_W is wiring.
  typedef struct packed {
    logic [4:0]       opcode;
    logic [2:0]       rd;
    logic [2:0]       rm;
    logic [2:0]       rn;
    logic [1:0]       alu_op;
    logic [3:0]       cond;
    logic [IMM_W-1:0] imm5;
    logic [IMM_W-1:0] imm8;
    logic [IMM_W-1:0] label8;
    logic [IMM_W-1:0] label11;
`ifdef DECODE_ILLEGAL_CHK_EN
    logic             illegal;
`endif
  } decoded_t;

endpackage

// File: rtl/instr_field_ext.sv
// Combinational field extraction and immediate extension for one instruction
// word. Adds the illegal-opcode flag when DECODE_ILLEGAL_CHK_EN is defined.
module instr_field_ext
  import instr_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output decoded_t           dec
);

  always_comb begin
    dec         = '0;
    dec.opcode  = instr[OPC_HI:OPC_LO];
    dec.rd      = instr[RD_HI:RD_LO];
    dec.rm      = instr[RM_HI:RM_LO];
    dec.rn      = instr[RN_HI:RN_LO];
    dec.alu_op  = instr[ALU_HI:ALU_LO];
    dec.cond    = instr[COND_HI:COND_LO];
    dec.imm5    = IMM_W'($signed(instr[IMM5_HI:0]));
    dec.imm8    = IMM_W'(instr[IMM8_HI:0]);
    dec.label8  = IMM_W'($signed(instr[LBL8_HI:0]));
    dec.label11 = IMM_W'($signed(instr[LBL11_HI:0]));
`ifdef DECODE_ILLEGAL_CHK_EN
    dec.illegal = !((instr[OPC_HI -: 2] == OPC_GRP_00)   ||
                    (instr[OPC_HI:OPC_LO] == OPC_10000)  ||
                    (instr[OPC_HI -: 4] == OPC_GRP_1100) ||
                    (instr[OPC_HI:OPC_LO] == OPC_11100));
`endif
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Instruction queue that decodes words on push and presents the head entry
// from a dedicated register. Optional Illegal output: DECODE_ILLEGAL_CHK_EN.
module instr_decode_queue
  import instr_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       In_Valid,
  input  logic [INSTR_W-1:0]         Instr_Input,
  output logic                       In_Ready,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [4:0]                 Opcode,
  output logic [2:0]                 Rd,
  output logic [2:0]                 Rm,
  output logic [2:0]                 Rn,
  output logic [1:0]                 ALU_Op,
  output logic [3:0]                 Cond,
  output logic [DATA_W-1:0]          Imm5,
  output logic [DATA_W-1:0]          Imm8,
  output logic [DATA_W-1:0]          Label8,
  output logic [DATA_W-1:0]          Label11,
  output logic [$clog2(DEPTH):0]     Count
`ifdef DECODE_ILLEGAL_CHK_EN
  ,
  output logic                       Illegal
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_t        mem [DEPTH];
  decoded_t        head_q;
  decoded_t        dec_in;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   next_rd;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;

  instr_field_ext u_field_ext (
    .instr (Instr_Input),
    .dec   (dec_in)
  );

  assign In_Ready  = (count_q != CW'(DEPTH));
  assign Out_Valid = (count_q != '0);
  assign push      = In_Valid && In_Ready;
  assign pop       = Out_Valid && Out_Ready;
  assign next_rd   = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + CW'(1);
    else if (!push && pop)
      count_next = count_q - CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (Flush) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr  <= next_rd;
      count_q <= count_next;
      // The new head is the word being written when the queue drains to it;
      // otherwise it is already in storage. Empty: hold the last head.
      if (count_next != '0)
        head_q <= (push && (next_rd == wr_ptr)) ? dec_in : mem[next_rd];
    end
  end

  assign Count   = count_q;
  assign Opcode  = head_q.opcode;
  assign Rd      = head_q.rd;
  assign Rm      = head_q.rm;
  assign Rn      = head_q.rn;
  assign ALU_Op  = head_q.alu_op;
  assign Cond    = head_q.cond;
  assign Imm5    = DATA_W'($signed(head_q.imm5));
  assign Imm8    = DATA_W'(head_q.imm8);
  assign Label8  = DATA_W'($signed(head_q.label8));
  assign Label11 = DATA_W'($signed(head_q.label11));
`ifdef DECODE_ILLEGAL_CHK_EN
  assign Illegal = head_q.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: vector table plus hand-written
// full, flush, reset and (with DECODE_ILLEGAL_CHK_EN) illegal-opcode sequences.
module tb_instr_decode_queue;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              Clk = 1'b0;
  logic              Reset, Flush, In_Valid, Out_Ready;
  logic [15:0]       Instr_Input;
  logic              In_Ready, Out_Valid;
  logic [4:0]        Opcode;
  logic [2:0]        Rd, Rm, Rn;
  logic [1:0]        ALU_Op;
  logic [3:0]        Cond;
  logic [DATA_W-1:0] Imm5, Imm8, Label8, Label11;
  logic [CW-1:0]     Count;
`ifdef DECODE_ILLEGAL_CHK_EN
  logic              Illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid),
    .Instr_Input(Instr_Input), .In_Ready(In_Ready), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Opcode(Opcode), .Rd(Rd), .Rm(Rm), .Rn(Rn),
    .ALU_Op(ALU_Op), .Cond(Cond), .Imm5(Imm5), .Imm8(Imm8),
    .Label8(Label8), .Label11(Label11), .Count(Count)
`ifdef DECODE_ILLEGAL_CHK_EN
    , .Illegal(Illegal)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  rd, rm, rn;
    logic [1:0]  alu_op;
    logic [3:0]  cond;
    logic [15:0] imm5, imm8, label8, label11;
  } exp_t;

  typedef struct {
    logic          flush, in_valid, out_ready;
    logic [15:0]   instr;
    logic          exp_valid, exp_in_ready;
    logic [CW-1:0] exp_count;
    exp_t          exp_dec;
  } vec_t;

  localparam logic [15:0] W1 = 16'h0AF0;  // 00001_010_11110000
  localparam logic [15:0] W2 = 16'h3958;  // 00111_001_010_11000
  localparam logic [15:0] W3 = 16'hC30F;  // 1100_0011_00001111
  localparam logic [15:0] W4 = 16'h87FF;  // 10000_11111111111

  exp_t d1, d2, d3, d4;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input exp_t e);
    check({tag, ".opcode"},  32'(Opcode),  32'(e.opcode));
    check({tag, ".rd"},      32'(Rd),      32'(e.rd));
    check({tag, ".rm"},      32'(Rm),      32'(e.rm));
    check({tag, ".rn"},      32'(Rn),      32'(e.rn));
    check({tag, ".alu_op"},  32'(ALU_Op),  32'(e.alu_op));
    check({tag, ".cond"},    32'(Cond),    32'(e.cond));
    check({tag, ".imm5"},    32'(Imm5),    32'(e.imm5));
    check({tag, ".imm8"},    32'(Imm8),    32'(e.imm8));
    check({tag, ".label8"},  32'(Label8),  32'(e.label8));
    check({tag, ".label11"}, 32'(Label11), 32'(e.label11));
  endtask

  task automatic check_status(input string tag, input logic v, input logic r, input int c);
    check({tag, ".out_valid"}, 32'(Out_Valid), 32'(v));
    check({tag, ".in_ready"},  32'(In_Ready),  32'(r));
    check({tag, ".count"},     32'(Count),     32'(c));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic fl, input logic iv, input logic [15:0] w, input logic ordy);
    Flush = fl; In_Valid = iv; Instr_Input = w; Out_Ready = ordy;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    d1 = '{5'b00001, 3'b010, 3'b111, 3'b100, 2'b00, 4'hA, 16'hFFF0, 16'h00F0, 16'hFFF0, 16'h02F0};
    d2 = '{5'b00111, 3'b001, 3'b010, 3'b110, 2'b00, 4'h9, 16'hFFF8, 16'h0058, 16'h0058, 16'h0158};
    d3 = '{5'b11000, 3'b011, 3'b000, 3'b011, 2'b11, 4'h3, 16'h000F, 16'h000F, 16'h000F, 16'h030F};
    d4 = '{5'b10000, 3'b111, 3'b111, 3'b111, 2'b11, 4'h7, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'hFFFF};

    //          flush iv    ordy  instr  valid rdy   cnt   head
    vecs[0] = '{1'b0, 1'b1, 1'b0, W1,    1'b1, 1'b1, 2'd1, d1};  // push into empty
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 2'd0, d1};  // pop, fields held
    vecs[2] = '{1'b0, 1'b1, 1'b0, W2,    1'b1, 1'b1, 2'd1, d2};
    vecs[3] = '{1'b0, 1'b1, 1'b1, W3,    1'b1, 1'b1, 2'd1, d3};  // push+pop, count kept
    vecs[4] = '{1'b0, 1'b1, 1'b0, W4,    1'b1, 1'b0, 2'd2, d3};  // full
    vecs[5] = '{1'b0, 1'b1, 1'b1, W1,    1'b1, 1'b1, 2'd1, d4};  // full: pop only
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 2'd0, d4};

    Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Instr_Input = '0; Out_Ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_status("reset", 1'b0, 1'b1, 0);
    check_head("reset", '0);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].flush, vecs[i].in_valid, vecs[i].instr, vecs[i].out_ready);
      check_status($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_in_ready,
                   int'(vecs[i].exp_count));
      check_head($sformatf("vec%0d", i), vecs[i].exp_dec);
    end

    // Fill, offer an extra word while full, then drain in order.
    step(1'b0, 1'b1, W1, 1'b0);
    step(1'b0, 1'b1, W2, 1'b0);
    check_status("full", 1'b1, 1'b0, DEPTH);
    step(1'b0, 1'b1, W3, 1'b0);
    check_status("full_ignore", 1'b1, 1'b0, DEPTH);
    check_head("full_first", d1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check_status("full_pop1", 1'b1, 1'b1, 1);
    check_head("full_pop1", d2);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check_status("full_pop2", 1'b0, 1'b1, 0);

    // Flush with Count = 2 and a word offered.
    step(1'b0, 1'b1, W1, 1'b0);
    step(1'b0, 1'b1, W2, 1'b0);
    step(1'b1, 1'b1, W3, 1'b1);
    check_status("flush2", 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check_status("flush2_after", 1'b0, 1'b1, 0);

    // Flush with room to push: the offered word must still be dropped.
    step(1'b0, 1'b1, W1, 1'b0);
    step(1'b1, 1'b1, W2, 1'b0);
    check_status("flush1", 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, W4, 1'b0);
    check_status("post_flush_push", 1'b1, 1'b1, 1);
    check_head("post_flush_push", d4);

    // Reset mid-stream beats push and pop and clears the head registers.
    step(1'b0, 1'b1, W2, 1'b0);
    Reset = 1'b1;
    step(1'b0, 1'b1, W3, 1'b1);
    Reset = 1'b0;
    check_status("mid_reset", 1'b0, 1'b1, 0);
    check_head("mid_reset", '0);

`ifdef DECODE_ILLEGAL_CHK_EN
    step(1'b0, 1'b1, 16'h4000, 1'b0);
    check("illegal_01000", 32'(Illegal), 32'd1);
    step(1'b0, 1'b1, 16'hE0C0, 1'b1);
    check("illegal_11100", 32'(Illegal), 32'd0);
    check("illegal_11100.rm", 32'(Rm), 32'd6);
    check("illegal_11100.opcode", 32'(Opcode), 32'h1C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode_queue.md
INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning instruction queue entries (power of two, 2..8).
REQ-002 SHALL have parameter DATA_W, default 16, meaning width of the extended immediate outputs (>=16).
REQ-003 SHALL have port Clk  in  1  the single clock; every register updates on the rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Flush  in  1  discards all queued entries.
REQ-006 SHALL have port In_Valid  in  1  Instr_Input is valid.
REQ-007 SHALL have port Instr_Input  in  16  fetched instruction word.
REQ-008 SHALL have port In_Ready  out  1  queue accepts a word.
REQ-009 SHALL have port Out_Valid  out  1  head entry is valid.
REQ-010 SHALL have port Out_Ready  in  1  consumer takes the head entry.
REQ-011 SHALL have port Opcode  out  5  head instruction [15:11].
REQ-012 SHALL have ports Rd, Rm, Rn  out  3 each  head instruction [10:8], [7:5], [4:2].
REQ-013 SHALL have ports ALU_Op  out  2  [1:0], and Cond  out  4  [11:8].
REQ-014 SHALL have ports Imm5, Imm8, Label8, Label11  out  DATA_W each  extended immediates.
REQ-015 SHALL have port Count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push when In_Valid && In_Ready, and pop when Out_Valid && Out_Ready.
REQ-017 SHALL drive In_Ready = (Count != DEPTH); when full, a simultaneous pop does not enable a push that cycle.
REQ-018 SHALL drive Out_Valid = (Count != 0); there is no empty-queue bypass.
REQ-019 SHALL present a word pushed in cycle N at the head in cycle N+1 at the earliest.
REQ-020 SHALL decode the fields in REQ-011..REQ-013 at push time and store them per entry, so every decoded output is a register output.
REQ-021 SHALL sign-extend Imm5 = [4:0], Label8 = [7:0], and Label11 = [10:0] to DATA_W.
REQ-022 SHALL zero-extend Imm8 = [7:0] to DATA_W.
REQ-023 SHALL on a simultaneous push and pop with 0 < Count < DEPTH keep Count unchanged and preserve order.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL give Flush priority over push and pop in the same cycle: Count becomes 0, pointers return to 0, and the input word is dropped.
REQ-026 SHALL hold the decoded outputs at their last values while Out_Valid = 0; the consumer ignores them.

Reset
REQ-027 SHALL, on Reset, set Count = 0 and both pointers = 0, giving Out_Valid = 0 and In_Ready = 1.
REQ-028 SHALL, on Reset, clear all decoded output registers to 0.
REQ-029 SHALL give Reset precedence over Flush, push and pop, including mid-stream.

Configuration
REQ-030 SHALL, with DECODE_ILLEGAL_CHK_EN defined, add port Illegal  out  1, stored per entry.
REQ-031 SHALL assert Illegal = 1 unless Opcode[4:3] = 00, Opcode = 10000, Opcode[4:1] = 1100, or Opcode = 11100; Reset value is 0.
REQ-032 SHALL, without DECODE_ILLEGAL_CHK_EN, have no Illegal port and no extra storage.

Structure
REQ-033 SHALL place field bit-position constants, the legal-opcode constants and the decoded-entry struct typedef in package instr_pkg.
REQ-034 SHALL implement the field extraction and extension as one combinational sub-module, instr_field_ext, instantiated once on the push path.

Verification
REQ-035 SHALL verify: push 16'b00001_010_11110000 into an empty queue -> next cycle Out_Valid = 1, Opcode = 00001, Rd = 010, Imm8 = 16'h00F0.
REQ-036 SHALL verify: push 16'b00111_001_010_11000 -> Opcode = 00111, Rd = 001, Rm = 010, Imm5 = 16'hFFF8.
REQ-037 SHALL verify: push 16'b1100_0011_00001111, then 16'b10000_11111111111 -> Cond = 0011, Label8 = 16'h000F, then Label11 = 16'hFFFF, in order.
REQ-038 SHALL verify: with Out_Ready = 0, push DEPTH words -> In_Ready = 0 and Count = DEPTH; a further In_Valid is ignored; one pop returns the first word.
REQ-039 SHALL verify: Flush asserted with In_Valid = 1 and Count = 2 -> next cycle Count = 0, Out_Valid = 0, and the word is dropped.
REQ-040 SHALL verify: with DECODE_ILLEGAL_CHK_EN, push 16'b01000_000_000_000_00 -> Illegal = 1, and push 16'b11100_000_110_000_00 -> Illegal = 0 and Rm = 110.
